// File: rtl/imem_fetch_responder_if.sv
// Fetch-side bus between the IF stage (master) and the instruction memory responder (slave).
// Both channels use valid/ready: a beat transfers on a rising edge where valid && ready; the
// sender holds valid and its payload stable until that edge, and valid never waits on ready.
interface imem_fetch_responder_if;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_inst;
  logic [63:0] resp_addr;
  logic        resp_err;

  modport master (
    output flush, req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_inst, resp_addr, resp_err
  );

  modport slave (
    input  flush, req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_inst, resp_addr, resp_err
  );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: fixed-latency, in-order fetch returns through a response FIFO
// whose depth equals the outstanding-request limit, so the latency pipeline never stalls.
module imem_fetch_responder #(
  parameter logic [63:0] BASE_ADDR       = 64'h8000_0000,
  parameter int          DEPTH_WORDS     = 65536,
  parameter int          LATENCY         = 2,
  parameter int          MAX_OUTSTANDING = 4,
  parameter string       INIT_FILE       = ""
) (
  input logic                   clk,
  input logic                   rst_n,
  imem_fetch_responder_if.slave bus
);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [63:0]      DEPTH_64  = 64'(DEPTH_WORDS);

  // Read-only store; contents are never reset.
  logic [31:0] mem_q [DEPTH_WORDS];

  logic             accept, pop, push, resp_valid;
  logic [63:0]      req_word;
  logic             req_err;
  logic             push_valid, push_err;
  logic [63:0]      push_addr;
  logic [IDX_W-1:0] push_idx;
  logic [31:0]      push_inst;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] fill_q, fill_d, cnt_q, cnt_d;
  logic [31:0]      f_inst_q [MAX_OUTSTANDING];
  logic [63:0]      f_addr_q [MAX_OUTSTANDING];
  logic             f_err_q  [MAX_OUTSTANDING];

  assign bus.req_ready = rst_n && (cnt_q < MAX_CNT) && !bus.flush;
  assign accept        = bus.req_valid && bus.req_ready;
  assign resp_valid    = (fill_q != '0) && !bus.flush;
  assign pop           = resp_valid && bus.resp_ready;

  // Fault is decided at accept time and travels with the request.
  assign req_word = (bus.req_addr - BASE_ADDR) >> 2;
  assign req_err  = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr < BASE_ADDR) ||
                    (req_word >= DEPTH_64);

  if (LATENCY == 1) begin : g_lat1
    assign push_valid = accept;
    assign push_addr  = bus.req_addr;
    assign push_err   = req_err;
  end else begin : g_pipe
    logic [LATENCY-2:0] v_q;
    logic [LATENCY-2:0] e_q;
    logic [63:0]        a_q [LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= '0;
      end else if (bus.flush) begin
        v_q <= '0;
      end else begin
        v_q[0] <= accept;
        for (int k = 1; k < LATENCY - 1; k++) v_q[k] <= v_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      a_q[0] <= bus.req_addr;
      e_q[0] <= req_err;
      for (int k = 1; k < LATENCY - 1; k++) begin
        a_q[k] <= a_q[k-1];
        e_q[k] <= e_q[k-1];
      end
    end

    assign push_valid = v_q[LATENCY-2];
    assign push_addr  = a_q[LATENCY-2];
    assign push_err   = e_q[LATENCY-2];
  end

  // Store is read in the last pipeline stage; faulting entries never touch it.
  assign push_idx  = IDX_W'((push_addr - BASE_ADDR) >> 2);
  assign push_inst = push_err ? 32'h0 : mem_q[push_idx];
  assign push      = push_valid && !bus.flush;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    if (bus.flush) begin
      wr_d   = '0;
      rd_d   = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wr_d = ptr_inc(wr_q);
      if (pop)  rd_d = ptr_inc(rd_q);
      if (push && !pop)      fill_d = fill_q + CNT_ONE;
      else if (!push && pop) fill_d = fill_q - CNT_ONE;
      if (accept && !pop)      cnt_d = cnt_q + CNT_ONE;
      else if (!accept && pop) cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

  // A full FIFO can still take a push when it pops the same cycle: the slot is freed first.
  always_ff @(posedge clk) begin
    if (push) begin
      f_inst_q[wr_q] <= push_inst;
      f_addr_q[wr_q] <= push_addr;
      f_err_q[wr_q]  <= push_err;
    end
  end

  assign bus.resp_valid = resp_valid;
  assign bus.resp_inst  = resp_valid ? f_inst_q[rd_q] : 32'h0;
  assign bus.resp_addr  = resp_valid ? f_addr_q[rd_q] : 64'h0;
  assign bus.resp_err   = resp_valid ? f_err_q[rd_q]  : 1'b0;
endmodule
